// File: rtl/conware_pkg.sv
// conware shared definitions: sequencer states,
// counter-width helper and generation-counter default.
package conware_pkg;

    localparam int GEN_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        FIN
    } state_t;

    // Counter width for a 0..n-1 range, never below 1 bit.
    function automatic int ctr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conware_frame_ctr.sv
// Positional column/row beat counter for one frame;
// flags the last column and the last beat of the frame.
module conware_frame_ctr
    import conware_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic beat,
    output logic col_last,
    output logic frame_last
);

    localparam int CW = ctr_w(WIDTH);
    localparam int RW = ctr_w(HEIGHT);
    localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          row_last;

    assign col_last   = (col == COL_MAX);
    assign row_last   = (row == ROW_MAX);
    assign frame_last = beat && col_last && row_last;

    // Column advances per beat; row advances on column wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col <= '0;
            row <= '0;
        end else if (beat) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/conware_gen_ctrl.sv
// Generation sequencer: admits one input frame per generation,
// waits for the output frame, counts generations, checks TLAST.
module conware_gen_ctrl
    import conware_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 1,
    parameter int GEN_W  = GEN_W_DEF
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             start,
    input  logic             abort,
    input  logic [GEN_W-1:0] num_gens,
    input  logic             s_beat,
    input  logic             s_last,
    input  logic             m_beat,
    output logic             s_enable,
    output logic             m_enable,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen_count,
    output logic             frame_err,
    output logic             aborted
);

    state_t           state;
    logic [GEN_W-1:0] gen_target;
    logic [GEN_W-1:0] gen_next;
    logic             out_done;
    logic             start_ok;
    logic             abort_ok;
    logic             in_beat;
    logic             out_beat;
    logic             ctr_clr;
    logic             gen_end;
    logic             in_col_last;
    logic             in_frame_last;
    logic             out_frame_last;
    logic             out_col_unused;

    assign s_enable = (state == LOAD);
    assign m_enable = (state == LOAD) || (state == DRAIN);
    assign busy     = (state != IDLE);
    assign done     = (state == FIN);

    assign start_ok = start && (state == IDLE);
    assign abort_ok = abort && (state != IDLE);
    assign in_beat  = s_beat && s_enable && !abort_ok;
    assign out_beat = m_beat && m_enable && !abort_ok;
    assign gen_next = gen_count + GEN_W'(1);

    // A generation ends when both frames are complete.
    assign gen_end = !abort_ok && (
        ((state == LOAD) && in_frame_last &&
         (out_done || out_frame_last)) ||
        ((state == DRAIN) && out_done));

    assign ctr_clr = start_ok || abort_ok || gen_end;

    conware_frame_ctr #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) u_in_ctr (
        .clk       (ACLK),
        .rst       (ARESET),
        .clr       (ctr_clr),
        .beat      (in_beat),
        .col_last  (in_col_last),
        .frame_last(in_frame_last)
    );

    conware_frame_ctr #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) u_out_ctr (
        .clk       (ACLK),
        .rst       (ARESET),
        .clr       (ctr_clr),
        .beat      (out_beat),
        .col_last  (out_col_unused),
        .frame_last(out_frame_last)
    );

    // Sequencer state, generation count and sticky flags.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= IDLE;
            gen_count  <= '0;
            gen_target <= '0;
            out_done   <= 1'b0;
            frame_err  <= 1'b0;
            aborted    <= 1'b0;
        end else if (abort_ok) begin
            state    <= IDLE;
            out_done <= 1'b0;
            aborted  <= 1'b1;
        end else begin
            if (in_beat && (s_last != in_col_last))
                frame_err <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        gen_target <= num_gens;
                        gen_count  <= '0;
                        frame_err  <= 1'b0;
                        aborted    <= 1'b0;
                        out_done   <= 1'b0;
                        state <= (num_gens == '0) ? FIN : LOAD;
                    end
                end
                LOAD, DRAIN: begin
                    if (gen_end) begin
                        gen_count <= gen_next;
                        out_done  <= 1'b0;
                        state <= (gen_next == gen_target) ? FIN : LOAD;
                    end else begin
                        if (out_frame_last)
                            out_done <= 1'b1;
                        if ((state == LOAD) && in_frame_last)
                            state <= DRAIN;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conware_gen_ctrl.sv
// Directed bench for conware_gen_ctrl (WIDTH=8, HEIGHT=2):
// 16 beats per frame, hand-computed cycle expectations.
module tb_conware_gen_ctrl;

    localparam int W  = 8;
    localparam int H  = 2;
    localparam int GW = 16;

    logic          clk = 1'b0;
    logic          ARESET;
    logic          start;
    logic          abort;
    logic [GW-1:0] num_gens;
    logic          s_beat;
    logic          s_last;
    logic          m_beat;
    logic          s_enable;
    logic          m_enable;
    logic          busy;
    logic          done;
    logic [GW-1:0] gen_count;
    logic          frame_err;
    logic          aborted;

    int checks   = 0;
    int failures = 0;

    bit        src_on;
    int        src_gap;
    int        lag;
    bit        bad_pending;
    int        in_col;
    int        in_row;
    int        out_avail;
    bit [15:0] pipe;
    int        cyc;

    conware_gen_ctrl #(
        .WIDTH (W),
        .HEIGHT(H),
        .GEN_W (GW)
    ) dut (
        .ACLK     (clk),
        .ARESET   (ARESET),
        .start    (start),
        .abort    (abort),
        .num_gens (num_gens),
        .s_beat   (s_beat),
        .s_last   (s_last),
        .m_beat   (m_beat),
        .s_enable (s_enable),
        .m_enable (m_enable),
        .busy     (busy),
        .done     (done),
        .gen_count(gen_count),
        .frame_err(frame_err),
        .aborted  (aborted)
    );

    always #5 clk = ~clk;

    // One cycle of source/sink behaviour, then observe #1 after the edge.
    task automatic step();
        bit v;
        bit arrive;
        int avail;
        v = src_on && !(src_gap > 0 && (cyc % src_gap) == src_gap - 1);
        s_beat = v && s_enable;
        s_last = s_beat && ((in_col == W - 1) ||
                 (bad_pending && in_row == 0 && in_col == 5));
        if (lag == 0) arrive = s_beat;
        else arrive = pipe[lag-1];
        avail = out_avail + int'(arrive);
        m_beat = (avail > 0) && m_enable;
        @(posedge clk);
        #1;
        out_avail = avail - int'(m_beat);
        pipe = {pipe[14:0], s_beat};
        if (s_beat) begin
            if (bad_pending && in_row == 0 && in_col == 5)
                bad_pending = 1'b0;
            if (in_col == W - 1) begin
                in_col = 0;
                in_row = (in_row == H - 1) ? 0 : in_row + 1;
            end else begin
                in_col++;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        cyc++;
    endtask

    task automatic prep(input int g, input int l, input int gap,
                        input bit bad);
        num_gens    = GW'(g);
        lag         = l;
        src_gap     = gap;
        bad_pending = bad;
        src_on      = 1'b1;
        in_col      = 0;
        in_row      = 0;
        out_avail   = 0;
        pipe        = '0;
        cyc         = 0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1; start = 1'b1; abort = 1'b0;
        num_gens = GW'(5);
        s_beat = 1'b0; s_last = 1'b0; m_beat = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (s_enable !== 1'b0) begin failures++;
            $display("FAIL reset_s_enable got %0d want 0", s_enable); end
        checks++; if (m_enable !== 1'b0) begin failures++;
            $display("FAIL reset_m_enable got %0d want 0", m_enable); end
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL reset_busy got %0d want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++;
            $display("FAIL reset_done got %0d want 0", done); end
        checks++; if (gen_count !== GW'(0)) begin failures++;
            $display("FAIL reset_gen_count got %0d want 0", gen_count); end
        checks++; if (frame_err !== 1'b0) begin failures++;
            $display("FAIL reset_frame_err got %0d want 0", frame_err); end
        checks++; if (aborted !== 1'b0) begin failures++;
            $display("FAIL reset_aborted got %0d want 0", aborted); end
        ARESET = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL reset_idle_busy got %0d want 0", busy); end
    endtask

    task automatic test_normal();
        int beats[4];
        int seen[4];
        int ncg, ndone, done_cyc, idle_cyc, gb;
        logic [GW-1:0] prev;
        beats = '{0, 0, 0, 0};
        seen  = '{-1, -1, -1, -1};
        ncg = 0; ndone = 0; done_cyc = -1; idle_cyc = -1;
        prep(3, 4, 0, 1'b0);
        start = 1'b1;
        step();
        checks++; if (s_enable !== 1'b1) begin failures++;
            $display("FAIL normal_start_lat got %0d want 1", s_enable); end
        prev = '0;
        for (int i = 0; i < 200; i++) begin
            if (gen_count != prev) begin
                if (ncg < 4) seen[ncg] = cyc;
                ncg++;
                prev = gen_count;
            end
            if (done) begin ndone++; done_cyc = cyc; end
            if (!busy) begin idle_cyc = cyc; break; end
            gb = int'(gen_count);
            step();
            if (s_beat && gb < 4) beats[gb]++;
        end
        checks++; if (idle_cyc !== 65) begin failures++;
            $display("FAIL normal_idle_cyc got %0d want 65", idle_cyc); end
        for (int g = 0; g < 3; g++) begin
            checks++; if (beats[g] !== 16) begin failures++;
                $display("FAIL normal_beats gen%0d got %0d want 16",
                         g, beats[g]); end
        end
        checks++; if (ncg !== 3) begin failures++;
            $display("FAIL normal_gen_steps got %0d want 3", ncg); end
        checks++; if (seen[0] !== 22 || seen[1] !== 43 || seen[2] !== 64)
            begin failures++;
            $display("FAIL normal_gen_cycles got %0d,%0d,%0d want 22,43,64",
                     seen[0], seen[1], seen[2]); end
        checks++; if (ndone !== 1) begin failures++;
            $display("FAIL normal_done_count got %0d want 1", ndone); end
        checks++; if (done_cyc !== 64) begin failures++;
            $display("FAIL normal_done_cyc got %0d want 64", done_cyc); end
        checks++; if (gen_count !== GW'(3)) begin failures++;
            $display("FAIL normal_gen_final got %0d want 3", gen_count); end
        checks++; if (frame_err !== 1'b0) begin failures++;
            $display("FAIL normal_frame_err got %0d want 0", frame_err); end
    endtask

    task automatic test_zero_gens();
        prep(0, 4, 0, 1'b0);
        start = 1'b1;
        step();
        checks++; if (done !== 1'b1 || busy !== 1'b1 || s_enable !== 1'b0)
            begin failures++;
            $display("FAIL zero_fin got done=%0d busy=%0d se=%0d want 1 1 0",
                     done, busy, s_enable); end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || s_enable !== 1'b0)
            begin failures++;
            $display("FAIL zero_idle got done=%0d busy=%0d se=%0d want 0 0 0",
                     done, busy, s_enable); end
        checks++; if (gen_count !== GW'(0)) begin failures++;
            $display("FAIL zero_gen_count got %0d want 0", gen_count); end
    endtask

    task automatic test_bad_tlast();
        int beats, done_cyc, idle_cyc;
        beats = 0; done_cyc = -1; idle_cyc = -1;
        prep(1, 4, 0, 1'b1);
        start = 1'b1;
        step();
        for (int i = 0; i < 100; i++) begin
            if (cyc == 6) begin
                checks++; if (frame_err !== 1'b0) begin failures++;
                    $display("FAIL badlast_before got %0d want 0",
                             frame_err); end
            end
            if (cyc == 7) begin
                checks++; if (frame_err !== 1'b1) begin failures++;
                    $display("FAIL badlast_set got %0d want 1",
                             frame_err); end
            end
            if (done) done_cyc = cyc;
            if (!busy) begin idle_cyc = cyc; break; end
            step();
            if (s_beat) beats++;
        end
        checks++; if (idle_cyc !== 23) begin failures++;
            $display("FAIL badlast_idle_cyc got %0d want 23", idle_cyc); end
        checks++; if (beats !== 16) begin failures++;
            $display("FAIL badlast_beats got %0d want 16", beats); end
        checks++; if (done_cyc !== 22) begin failures++;
            $display("FAIL badlast_done_cyc got %0d want 22", done_cyc); end
        checks++; if (frame_err !== 1'b1 || gen_count !== GW'(1))
            begin failures++;
            $display("FAIL badlast_end got ferr=%0d gen=%0d want 1 1",
                     frame_err, gen_count); end
    endtask

    task automatic test_abort();
        int ndone;
        ndone = 0;
        prep(4, 4, 0, 1'b1);
        start = 1'b1;
        step();
        while (cyc < 39) step();
        checks++; if (s_enable !== 1'b0 || busy !== 1'b1 ||
                      gen_count !== GW'(1)) begin failures++;
            $display("FAIL abort_in_drain got se=%0d busy=%0d gen=%0d want 0 1 1",
                     s_enable, busy, gen_count); end
        abort = 1'b1;
        step();
        checks++; if (busy !== 1'b0 || aborted !== 1'b1) begin failures++;
            $display("FAIL abort_idle got busy=%0d aborted=%0d want 0 1",
                     busy, aborted); end
        checks++; if (gen_count !== GW'(1)) begin failures++;
            $display("FAIL abort_gen_hold got %0d want 1", gen_count); end
        checks++; if (frame_err !== 1'b1) begin failures++;
            $display("FAIL abort_ferr_sticky got %0d want 1", frame_err); end
        if (done) ndone++;
        repeat (5) begin
            step();
            if (done || busy) ndone++;
        end
        checks++; if (ndone !== 0) begin failures++;
            $display("FAIL abort_no_done got %0d want 0", ndone); end
        prep(0, 4, 0, 1'b0);
        start = 1'b1;
        step();
        checks++; if (aborted !== 1'b0 || frame_err !== 1'b0 || done !== 1'b1)
            begin failures++;
            $display("FAIL abort_restart got ab=%0d ferr=%0d done=%0d want 0 0 1",
                     aborted, frame_err, done); end
        step();
    endtask

    task automatic test_back_to_back();
        int beats[4];
        int ncg, ndone, drain, idle_cyc, gb;
        logic [GW-1:0] prev;
        logic se_regen;
        beats = '{0, 0, 0, 0};
        ncg = 0; ndone = 0; drain = 0; idle_cyc = -1;
        se_regen = 1'bx;
        prep(2, 0, 3, 1'b0);
        start = 1'b1;
        step();
        prev = '0;
        for (int i = 0; i < 200; i++) begin
            if (gen_count != prev) begin
                if (ncg == 0) se_regen = s_enable;
                ncg++;
                prev = gen_count;
            end
            if (done) ndone++;
            if (busy && !s_enable && !done) drain++;
            if (!busy) begin idle_cyc = cyc; break; end
            if (cyc == 5) begin
                start = 1'b1;
                num_gens = GW'(9);
            end
            gb = int'(gen_count);
            step();
            if (s_beat && gb < 4) beats[gb]++;
        end
        checks++; if (idle_cyc < 0) begin failures++;
            $display("FAIL b2b_timeout got %0d want >=0", idle_cyc); end
        checks++; if (drain !== 0) begin failures++;
            $display("FAIL b2b_drain_cycles got %0d want 0", drain); end
        checks++; if (se_regen !== 1'b1) begin failures++;
            $display("FAIL b2b_reload got %0d want 1", se_regen); end
        checks++; if (beats[0] !== 16 || beats[1] !== 16) begin failures++;
            $display("FAIL b2b_beats got %0d,%0d want 16,16",
                     beats[0], beats[1]); end
        checks++; if (ndone !== 1) begin failures++;
            $display("FAIL b2b_done_count got %0d want 1", ndone); end
        checks++; if (gen_count !== GW'(2)) begin failures++;
            $display("FAIL b2b_gen_final got %0d want 2", gen_count); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_zero_gens();
        test_bad_tlast();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
